// File: rtl/alu_share_arbiter.sv
// Round-robin arbiter sharing one ALU between two requesters.
// Optional grant/stall counters are enabled by defining ALU_ARB_STATS_EN.
module alu_share_arbiter #(
   parameter int DATA_W  = 64,
   parameter int ALU_LAT = 1
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              r0_valid,
   output logic              r0_ready,
   input  logic [DATA_W-1:0] r0_a,
   input  logic [DATA_W-1:0] r0_b,
   input  logic [3:0]        r0_op,
   input  logic              r1_valid,
   output logic              r1_ready,
   input  logic [DATA_W-1:0] r1_a,
   input  logic [DATA_W-1:0] r1_b,
   input  logic [3:0]        r1_op,
   output logic [DATA_W-1:0] alu_a,
   output logic [DATA_W-1:0] alu_b,
   output logic [3:0]        alu_op,
   input  logic [DATA_W-1:0] alu_result,
   input  logic              alu_zero,
   output logic              resp_valid,
   input  logic              resp_ready,
   output logic              resp_id,
   output logic [DATA_W-1:0] resp_result,
   output logic              resp_zero
`ifdef ALU_ARB_STATS_EN
   ,
   output logic [31:0]       grant_cnt0,
   output logic [31:0]       grant_cnt1,
   output logic [31:0]       stall_cnt
`endif
);

   localparam logic [1:0] S_IDLE = 2'd0;
   localparam logic [1:0] S_EXEC = 2'd1;
   localparam logic [1:0] S_RESP = 2'd2;
   localparam logic [3:0] LAT_LAST = 4'(ALU_LAT - 1);

   logic [1:0]        state_q, state_d;
   logic              rr_q, rr_d;
   logic              id_q, id_d;
   logic [3:0]        cnt_q, cnt_d;
   logic [DATA_W-1:0] alu_a_q, alu_a_d;
   logic [DATA_W-1:0] alu_b_q, alu_b_d;
   logic [3:0]        alu_op_q, alu_op_d;
   logic              resp_valid_q, resp_valid_d;
   logic              resp_id_q, resp_id_d;
   logic [DATA_W-1:0] resp_result_q, resp_result_d;
   logic              resp_zero_q, resp_zero_d;
   logic              is_idle;
   logic              gnt0;
   logic              gnt1;

   // Grants are gated by reset so ready never rises while reset is held.
   assign is_idle = (state_q == S_IDLE) && !reset;
   assign gnt0 = is_idle && r0_valid && (!r1_valid || !rr_q);
   assign gnt1 = is_idle && r1_valid && (!r0_valid || rr_q);

   assign r0_ready    = gnt0;
   assign r1_ready    = gnt1;
   assign alu_a       = alu_a_q;
   assign alu_b       = alu_b_q;
   assign alu_op      = alu_op_q;
   assign resp_valid  = resp_valid_q;
   assign resp_id     = resp_id_q;
   assign resp_result = resp_result_q;
   assign resp_zero   = resp_zero_q;

   always_comb begin
      state_d       = state_q;
      rr_d          = rr_q;
      id_d          = id_q;
      cnt_d         = cnt_q;
      alu_a_d       = alu_a_q;
      alu_b_d       = alu_b_q;
      alu_op_d      = alu_op_q;
      resp_valid_d  = resp_valid_q;
      resp_id_d     = resp_id_q;
      resp_result_d = resp_result_q;
      resp_zero_d   = resp_zero_q;
      case (state_q)
         S_IDLE: begin
            if (gnt0 || gnt1) begin
               alu_a_d  = gnt1 ? r1_a  : r0_a;
               alu_b_d  = gnt1 ? r1_b  : r0_b;
               alu_op_d = gnt1 ? r1_op : r0_op;
               id_d     = gnt1;
               cnt_d    = 4'd0;
               state_d  = S_EXEC;
            end
         end
         S_EXEC: begin
            cnt_d = cnt_q + 4'd1;
            if (cnt_q == LAT_LAST) begin
               resp_result_d = alu_result;
               resp_zero_d   = alu_zero;
               resp_id_d     = id_q;
               resp_valid_d  = 1'b1;
               state_d       = S_RESP;
            end
         end
         S_RESP: begin
            if (resp_ready) begin
               resp_valid_d = 1'b0;
               rr_d         = ~id_q;
               state_d      = S_IDLE;
            end
         end
         default: state_d = S_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q       <= S_IDLE;
         rr_q          <= 1'b0;
         id_q          <= 1'b0;
         cnt_q         <= 4'd0;
         alu_a_q       <= '0;
         alu_b_q       <= '0;
         alu_op_q      <= 4'd0;
         resp_valid_q  <= 1'b0;
         resp_id_q     <= 1'b0;
         resp_result_q <= '0;
         resp_zero_q   <= 1'b0;
      end else begin
         state_q       <= state_d;
         rr_q          <= rr_d;
         id_q          <= id_d;
         cnt_q         <= cnt_d;
         alu_a_q       <= alu_a_d;
         alu_b_q       <= alu_b_d;
         alu_op_q      <= alu_op_d;
         resp_valid_q  <= resp_valid_d;
         resp_id_q     <= resp_id_d;
         resp_result_q <= resp_result_d;
         resp_zero_q   <= resp_zero_d;
      end
   end

`ifdef ALU_ARB_STATS_EN
   logic [31:0] gcnt0_q, gcnt1_q, stall_q;

   always_ff @(posedge clk) begin
      if (reset) begin
         gcnt0_q <= 32'd0;
         gcnt1_q <= 32'd0;
         stall_q <= 32'd0;
      end else begin
         if (gnt0) gcnt0_q <= gcnt0_q + 32'd1;
         if (gnt1) gcnt1_q <= gcnt1_q + 32'd1;
         if (state_q == S_RESP && !resp_ready)
            stall_q <= stall_q + 32'd1;
      end
   end

   assign grant_cnt0 = gcnt0_q;
   assign grant_cnt1 = gcnt1_q;
   assign stall_cnt  = stall_q;
`endif

endmodule

// File: tb/tb_alu_share_arbiter.sv
// Scoreboard bench for alu_share_arbiter (latency 1 and latency 3 instances).
module tb_alu_share_arbiter;

   typedef struct packed {
      logic        id;
      logic [63:0] res;
      logic        zero;
   } exp_t;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic        reset;
   logic        r0_valid, r0_ready, r1_valid, r1_ready;
   logic [63:0] r0_a, r0_b, r1_a, r1_b;
   logic [3:0]  r0_op, r1_op;
   logic [63:0] alu_a, alu_b, alu_result;
   logic [3:0]  alu_op;
   logic        alu_zero;
   logic        resp_valid, resp_ready, resp_id, resp_zero;
   logic [63:0] resp_result;

   logic        l_r0_valid, l_r0_ready, l_r1_valid, l_r1_ready;
   logic [63:0] l_r0_a, l_r0_b, l_r1_a, l_r1_b;
   logic [3:0]  l_r0_op, l_r1_op;
   logic [63:0] l_alu_a, l_alu_b, l_alu_result;
   logic [3:0]  l_alu_op;
   logic        l_alu_zero;
   logic        l_resp_valid, l_resp_ready, l_resp_id, l_resp_zero;
   logic [63:0] l_resp_result;

`ifdef ALU_ARB_STATS_EN
   logic [31:0] gc0, gc1, stc, l_gc0, l_gc1, l_stc;
`endif

   function automatic logic [63:0] alu_f(input logic [63:0] a,
                                         input logic [63:0] b,
                                         input logic [3:0]  op);
      case (op)
         4'b0000: return a & b;
         4'b0001: return a | b;
         4'b0010: return a + b;
         4'b0110: return a - b;
         4'b1100: return ~(a | b);
         default: return 64'd0;
      endcase
   endfunction

   assign alu_result   = alu_f(alu_a, alu_b, alu_op);
   assign alu_zero     = (alu_result == 64'd0);
   assign l_alu_result = alu_f(l_alu_a, l_alu_b, l_alu_op);
   assign l_alu_zero   = (l_alu_result == 64'd0);

   alu_share_arbiter #(.DATA_W(64), .ALU_LAT(1)) dut (
      .clk(clk), .reset(reset),
      .r0_valid(r0_valid), .r0_ready(r0_ready),
      .r0_a(r0_a), .r0_b(r0_b), .r0_op(r0_op),
      .r1_valid(r1_valid), .r1_ready(r1_ready),
      .r1_a(r1_a), .r1_b(r1_b), .r1_op(r1_op),
      .alu_a(alu_a), .alu_b(alu_b), .alu_op(alu_op),
      .alu_result(alu_result), .alu_zero(alu_zero),
      .resp_valid(resp_valid), .resp_ready(resp_ready),
      .resp_id(resp_id), .resp_result(resp_result),
      .resp_zero(resp_zero)
`ifdef ALU_ARB_STATS_EN
      , .grant_cnt0(gc0), .grant_cnt1(gc1), .stall_cnt(stc)
`endif
   );

   alu_share_arbiter #(.DATA_W(64), .ALU_LAT(3)) dut3 (
      .clk(clk), .reset(reset),
      .r0_valid(l_r0_valid), .r0_ready(l_r0_ready),
      .r0_a(l_r0_a), .r0_b(l_r0_b), .r0_op(l_r0_op),
      .r1_valid(l_r1_valid), .r1_ready(l_r1_ready),
      .r1_a(l_r1_a), .r1_b(l_r1_b), .r1_op(l_r1_op),
      .alu_a(l_alu_a), .alu_b(l_alu_b), .alu_op(l_alu_op),
      .alu_result(l_alu_result), .alu_zero(l_alu_zero),
      .resp_valid(l_resp_valid), .resp_ready(l_resp_ready),
      .resp_id(l_resp_id), .resp_result(l_resp_result),
      .resp_zero(l_resp_zero)
`ifdef ALU_ARB_STATS_EN
      , .grant_cnt0(l_gc0), .grant_cnt1(l_gc1), .stall_cnt(l_stc)
`endif
   );

   int   n_chk  = 0;
   int   n_fail = 0;
   int   n_resp = 0;
   int   n_resp3 = 0;
   int   n_exp  = 0;
   exp_t q[$];
   exp_t q3[$];

   task automatic chk(input string nm, input logic [63:0] got,
                      input logic [63:0] want);
      n_chk++;
      if (got !== want) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", nm, got, want);
      end
   endtask

   task automatic push(input logic id, input logic [63:0] r,
                       input logic z);
      exp_t e;
      e.id = id; e.res = r; e.zero = z;
      q.push_back(e);
      n_exp++;
   endtask

   task automatic wait_resp(input int budget);
      int i;
      i = 0;
      while (n_resp < n_exp && i < budget) begin
         @(posedge clk); #1;
         i++;
      end
      chk("resp_timeout", 64'(n_resp), 64'(n_exp));
   endtask

   always @(negedge clk) begin
      if (!reset && resp_valid && resp_ready) begin
         if (q.size() == 0) begin
            chk("unexpected_resp", 64'd1, 64'd0);
         end else begin
            exp_t e;
            e = q.pop_front();
            chk("resp_id", 64'(resp_id), 64'(e.id));
            chk("resp_result", resp_result, e.res);
            chk("resp_zero", 64'(resp_zero), 64'(e.zero));
         end
         n_resp++;
      end
   end

   always @(negedge clk) begin
      if (!reset && l_resp_valid && l_resp_ready) begin
         if (q3.size() == 0) begin
            chk("unexpected_resp3", 64'd1, 64'd0);
         end else begin
            exp_t e;
            e = q3.pop_front();
            chk("lat3_resp_id", 64'(l_resp_id), 64'(e.id));
            chk("lat3_resp_result", l_resp_result, e.res);
            chk("lat3_resp_zero", 64'(l_resp_zero), 64'(e.zero));
         end
         n_resp3++;
      end
   end

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "watchdog");
   end

   initial begin
      exp_t e3;
      int k;
      reset = 1'b1;
      resp_ready = 1'b1;
      r0_valid = 1'b1; r0_a = 64'd10; r0_b = 64'd15; r0_op = 4'b0000;
      r1_valid = 1'b0; r1_a = '0; r1_b = '0; r1_op = '0;
      l_r0_valid = 1'b0; l_r0_a = '0; l_r0_b = '0; l_r0_op = '0;
      l_r1_valid = 1'b0; l_r1_a = '0; l_r1_b = '0; l_r1_op = '0;
      l_resp_ready = 1'b1;

      // reset state, with a request pending
      repeat (2) @(posedge clk);
      @(negedge clk);
      chk("rst_r0_ready", 64'(r0_ready), 64'd0);
      chk("rst_resp_valid", 64'(resp_valid), 64'd0);
      chk("rst_alu_a", alu_a, 64'd0);
      chk("rst_alu_op", 64'(alu_op), 64'd0);
      chk("rst_resp_result", resp_result, 64'd0);

      // single requester, AND
      @(posedge clk); #1;
      reset = 1'b0;
      push(1'b0, 64'd10, 1'b0);
      @(negedge clk);
      chk("t1_r0_ready_c0", 64'(r0_ready), 64'd1);
      chk("t1_r1_ready_c0", 64'(r1_ready), 64'd0);
      @(posedge clk); #1;
      r0_valid = 1'b0;
      @(negedge clk);
      chk("t1_valid_c1", 64'(resp_valid), 64'd0);
      chk("t1_alu_a", alu_a, 64'd10);
      chk("t1_alu_b", alu_b, 64'd15);
      @(negedge clk);
      chk("t1_valid_c2", 64'(resp_valid), 64'd1);
      wait_resp(10);

      // contention: 6 operations alternate 0,1,0,1,0,1
      @(posedge clk); #1;
      reset = 1'b1;
      @(posedge clk); #1;
      reset = 1'b0;
      r0_valid = 1'b1; r0_a = 64'd10; r0_b = 64'd15; r0_op = 4'b0010;
      r1_valid = 1'b1; r1_a = 64'd15; r1_b = 64'd15; r1_op = 4'b0110;
      for (int i = 0; i < 3; i++) begin
         push(1'b0, 64'd25, 1'b0);
         push(1'b1, 64'd0, 1'b1);
      end
      wait_resp(100);
      r0_valid = 1'b0;
      r1_valid = 1'b0;

      // backpressure for 5 cycles in RESP
      resp_ready = 1'b0;
      r0_valid = 1'b1; r0_a = 64'd5; r0_b = 64'd3; r0_op = 4'b0001;
      r1_valid = 1'b1;
      push(1'b0, 64'd7, 1'b0);
      for (k = 0; k < 20; k++) begin
         @(negedge clk);
         if (resp_valid) break;
      end
      chk("t3_resp_seen", 64'(resp_valid), 64'd1);
      for (int i = 0; i < 5; i++) begin
         chk("t3_hold_valid", 64'(resp_valid), 64'd1);
         chk("t3_hold_result", resp_result, 64'd7);
         chk("t3_hold_id", 64'(resp_id), 64'd0);
         chk("t3_r0_ready", 64'(r0_ready), 64'd0);
         chk("t3_r1_ready", 64'(r1_ready), 64'd0);
         if (i < 4) @(negedge clk);
      end
      @(posedge clk); #1;
      resp_ready = 1'b1;
      r0_valid = 1'b0;
      r1_valid = 1'b0;
      @(negedge clk);
      chk("t3_valid_at_ready", 64'(resp_valid), 64'd1);
`ifdef ALU_ARB_STATS_EN
      chk("t3_stall_cnt", 64'(stc), 64'd5);
`endif
      @(negedge clk);
      chk("t3_done", 64'(resp_valid), 64'd0);
      wait_resp(10);

      // operand change after grant, NOR
      @(posedge clk); #1;
      r0_valid = 1'b1; r0_a = 64'd3; r0_b = 64'd0; r0_op = 4'b1100;
      push(1'b0, 64'hFFFF_FFFF_FFFF_FFFC, 1'b0);
      @(negedge clk);
      chk("t4_r0_ready", 64'(r0_ready), 64'd1);
      @(posedge clk); #1;
      r0_valid = 1'b0;
      r0_a = 64'd7;
      wait_resp(10);

      // reset during EXEC
      @(posedge clk); #1;
      r0_valid = 1'b1; r0_a = 64'd1; r0_b = 64'd2; r0_op = 4'b0010;
      @(posedge clk); #1;
      r0_valid = 1'b0;
      reset = 1'b1;
      @(posedge clk); #1;
      reset = 1'b0;
      @(negedge clk);
      chk("t5_alu_a", alu_a, 64'd0);
      chk("t5_alu_b", alu_b, 64'd0);
      chk("t5_alu_op", 64'(alu_op), 64'd0);
      chk("t5_resp_result", resp_result, 64'd0);
      chk("t5_resp_id", 64'(resp_id), 64'd0);
      chk("t5_resp_zero", 64'(resp_zero), 64'd0);
      for (int i = 0; i < 5; i++) begin
         chk("t5_no_resp", 64'(resp_valid), 64'd0);
         @(negedge clk);
      end
      @(posedge clk); #1;
      r0_valid = 1'b1; r0_a = 64'd10; r0_b = 64'd15; r0_op = 4'b0010;
      r1_valid = 1'b1; r1_a = 64'd15; r1_b = 64'd15; r1_op = 4'b0110;
      push(1'b0, 64'd25, 1'b0);
      @(negedge clk);
      chk("t5_r0_ready", 64'(r0_ready), 64'd1);
      chk("t5_r1_ready", 64'(r1_ready), 64'd0);
      @(posedge clk); #1;
      r0_valid = 1'b0;
      r1_valid = 1'b0;
      wait_resp(10);

      // latency 3 instance, SUB on requester 1
      @(posedge clk); #1;
      l_r1_valid = 1'b1; l_r1_a = 64'd5; l_r1_b = 64'd5;
      l_r1_op = 4'b0110;
      e3.id = 1'b1; e3.res = 64'd0; e3.zero = 1'b1;
      q3.push_back(e3);
      @(negedge clk);
      chk("t6_r1_ready", 64'(l_r1_ready), 64'd1);
      @(posedge clk); #1;
      l_r1_valid = 1'b0;
      for (int i = 1; i <= 3; i++) begin
         @(negedge clk);
         chk("t6_early_valid", 64'(l_resp_valid), 64'd0);
      end
      @(negedge clk);
      chk("t6_valid_c4", 64'(l_resp_valid), 64'd1);
      repeat (3) @(posedge clk);
      #1;

      chk("lat3_resp_count", 64'(n_resp3), 64'd1);
      chk("queue_empty", 64'(q.size()), 64'd0);
      chk("queue3_empty", 64'(q3.size()), 64'd0);
      $display("End of test - %0d assertions evaluated, %0d failures",
               n_chk, n_fail);
      $finish;
   end

endmodule
